boa_pwr_seq: RTL and testbench
==============================

Name: boa_pwr_seq

Overview:
- Power and reset sequencer between the board inputs (center button, PMU bus requests) and the SoC core's reset and clock-gate inputs.
- Synchronises and debounces the raw reset button.
- Arbitrates PMU reset and shutdown requests, stretches core reset to a fixed length, and drains before gating the core clock.
- Reports the cause of the last reset to software.

Parameters:
- debounce_cycles, 1000000, clk cycles the synchronised button must differ from the debounced value before it is accepted (10 ms at 100 MHz); minimum 1.
- rst_hold, 16, cycles core_rst stays high per reset entry; minimum 1.
- shdn_drain, 4, cycles spent in DRAIN before core_shdn asserts; minimum 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- btn_raw  in  1  asynchronous raw reset/wake button, active-high.
- pmu_rst  in  1  PMU reset request, level, sampled every cycle.
- pmu_shdn  in  1  PMU shutdown request, level, sampled every cycle.
- core_rst  out  1  active-high core reset.
- core_shdn  out  1  core clock gate, 1 = gated.
- rst_cause  out  2  cause of last reset: 0 = POR, 1 = button, 2 = PMU, 3 = wake from shutdown.
- btn_db  out  1  debounced button level.

Behaviour:
- Reset and timing: all state updates only on posedge clk. rst_n=0 for any cycle forces the following, regardless of current state, including mid-SHDN or mid-DRAIN:
  - state=RESET, hold counter=0;
  - core_rst=1, core_shdn=0, rst_cause=0, btn_db=0;
  - sync flops=0, debounce counter=0.
- Outputs: core_rst and core_shdn are Moore decodes of the registered state.
  - core_rst=1 only in RESET.
  - core_shdn=1 only in SHDN.
  - No glitching.
- Synchroniser: 2 flops on btn_raw.
- Debounce:
  - If sync != btn_db, counter increments. When counter == debounce_cycles-1 and still differing, btn_db <= sync and counter <= 0.
  - If sync == btn_db, counter <= 0.
  - A stable btn_raw change reaches btn_db 2+debounce_cycles edges later.
  - Any bounce shorter than debounce_cycles is ignored.
  - Counter width is $clog2(debounce_cycles+1).
- Press: a one-cycle internal pulse on the btn_db 0→1 transition. Release has no effect.
- States: RESET, RUN, DRAIN, SHDN.
- RESET:
  - Hold counter increments each cycle; on reaching rst_hold-1, go to RUN.
  - core_rst is therefore high for exactly rst_hold cycles per entry.
  - Press or pmu_rst while in RESET restarts the counter to 0 and updates rst_cause (button=1 beats PMU=2).
- RUN:
  - Priority: press → RESET, cause=1; else pmu_rst → RESET, cause=2; else pmu_shdn → DRAIN.
- DRAIN:
  - core_rst=0, core_shdn=0. Counter runs shdn_drain cycles, then SHDN.
  - Press → RESET, cause=1; pmu_rst → RESET, cause=2. Both abort the shutdown.
  - pmu_shdn deasserting does not abort.
- SHDN:
  - core_shdn=1. Only press exits: RESET with cause=3, so core_shdn falls and core_rst rises on the same edge.
  - pmu_rst and pmu_shdn are ignored (core is gated).
- State transitions and cause updates take effect on the edge the event is sampled. rst_cause holds its value until the next reset entry.
- Shared hold/drain counter, width $clog2(max(rst_hold, shdn_drain)+1); cleared on every state entry.
- pmu_rst held high in RUN yields back-to-back resets; this is intended, and the PMU is responsible for clearing it.

Test Plan (debounce_cycles=8, rst_hold=4, shdn_drain=3):
- Deassert rst_n → core_rst=1 for exactly 4 edges, then 0; rst_cause=0; core_shdn=0 throughout.
- btn_raw glitches high for 1–5 cycles at a time, several times → btn_db stays 0, no reset. Then btn_raw held high → btn_db=1 exactly 10 edges after the rise; core_rst=1 on the same edge for 4 cycles; rst_cause=1.
- In RUN, pulse pmu_shdn 1 cycle → core_shdn=1 exactly 3 cycles after DRAIN entry and stays. Press → core_shdn=0 and core_rst=1 on the same edge; rst_cause=3; RUN after 4 cycles.
- In RUN, press and pmu_rst on the same cycle → RESET with rst_cause=1. pmu_rst alone later → rst_cause=2.
- pmu_shdn, then pmu_rst on the 2nd DRAIN cycle → RESET, cause=2; core_shdn never asserts.
- rst_n=0 for 1 cycle while in SHDN with rst_cause=3 → next edge core_shdn=0, core_rst=1, rst_cause=0, btn_db=0.
- In RESET, pmu_rst on the 3rd hold cycle → hold restarts; core_rst is high 3+4=7 cycles total; rst_cause=2.

Source files
------------

// File: rtl/boa_pwr_seq.sv
// Power/reset sequencer: button synchroniser and debounce, PMU reset/shutdown
// arbitration, fixed-length core reset stretch, drain-then-gate shutdown.
module boa_pwr_seq #(
    parameter int unsigned debounce_cycles = 1000000,
    parameter int unsigned rst_hold        = 16,
    parameter int unsigned shdn_drain      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_raw,
    input  logic       pmu_rst,
    input  logic       pmu_shdn,
    output logic       core_rst,
    output logic       core_shdn,
    output logic [1:0] rst_cause,
    output logic       btn_db
);

    localparam int unsigned DbW     = $clog2(debounce_cycles + 1);
    localparam int unsigned CntMax  = (rst_hold > shdn_drain) ? rst_hold : shdn_drain;
    localparam int unsigned CntW    = $clog2(CntMax + 1);

    localparam logic [DbW-1:0]  DbLast    = DbW'(debounce_cycles - 1);
    localparam logic [CntW-1:0] HoldLast  = CntW'(rst_hold - 1);
    localparam logic [CntW-1:0] DrainLast = CntW'(shdn_drain - 1);

    localparam logic [1:0] CausePor  = 2'd0;
    localparam logic [1:0] CauseBtn  = 2'd1;
    localparam logic [1:0] CausePmu  = 2'd2;
    localparam logic [1:0] CauseWake = 2'd3;

    typedef enum logic [1:0] {StReset, StRun, StDrain, StShdn} state_e;

    logic           sync1_q, sync2_q;
    logic [DbW-1:0] db_cnt_q, db_cnt_d;
    logic           btn_db_q, btn_db_d;
    logic           press;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      cause_q, cause_d;
    logic            core_rst_q, core_shdn_q;

    // Debounce: accept the synchronised level once it has differed long enough.
    always_comb begin
        db_cnt_d = '0;
        btn_db_d = btn_db_q;
        if (sync2_q != btn_db_q) begin
            if (db_cnt_q == DbLast) begin
                btn_db_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Press is taken from the next-state value so the FSM reacts on the same
    // edge that btn_db rises.
    assign press = btn_db_d & ~btn_db_q;

    // Synchroniser and debounce state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            db_cnt_q <= '0;
            btn_db_q <= 1'b0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            db_cnt_q <= db_cnt_d;
            btn_db_q <= btn_db_d;
        end
    end

    // Sequencer next state, shared hold/drain counter and reset cause.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        case (state_q)
            StReset: begin
                if (press || pmu_rst) begin
                    cnt_d   = '0;
                    cause_d = press ? CauseBtn : CausePmu;
                end else if (cnt_q == HoldLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (press) begin
                    state_d = StReset;
                    cnt_d   = '0;
                    cause_d = CauseBtn;
                end else if (pmu_rst) begin
                    state_d = StReset;
                    cnt_d   = '0;
                    cause_d = CausePmu;
                end else if (pmu_shdn) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end
            end
            StDrain: begin
                // Dropping pmu_shdn here does not cancel the shutdown.
                if (press) begin
                    state_d = StReset;
                    cnt_d   = '0;
                    cause_d = CauseBtn;
                end else if (pmu_rst) begin
                    state_d = StReset;
                    cnt_d   = '0;
                    cause_d = CausePmu;
                end else if (cnt_q == DrainLast) begin
                    state_d = StShdn;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShdn: begin
                // Core is gated; only the button can wake it.
                if (press) begin
                    state_d = StReset;
                    cnt_d   = '0;
                    cause_d = CauseWake;
                end
            end
            default: begin
                state_d = StReset;
                cnt_d   = '0;
            end
        endcase
    end

    // Sequencer state plus registered output decodes (glitch-free).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StReset;
            cnt_q       <= '0;
            cause_q     <= CausePor;
            core_rst_q  <= 1'b1;
            core_shdn_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cause_q     <= cause_d;
            core_rst_q  <= (state_d == StReset);
            core_shdn_q <= (state_d == StShdn);
        end
    end

    assign core_rst  = core_rst_q;
    assign core_shdn = core_shdn_q;
    assign rst_cause = cause_q;
    assign btn_db    = btn_db_q;

endmodule

// File: tb/tb_boa_pwr_seq.sv
// Directed bench for boa_pwr_seq (debounce_cycles=8, rst_hold=4, shdn_drain=3).
module tb_boa_pwr_seq;

    logic       clk;
    logic       rst_n;
    logic       btn_raw;
    logic       pmu_rst;
    logic       pmu_shdn;
    logic       core_rst;
    logic       core_shdn;
    logic [1:0] rst_cause;
    logic       btn_db;

    int n_assert = 0;
    int n_fail   = 0;

    boa_pwr_seq #(
        .debounce_cycles(8),
        .rst_hold       (4),
        .shdn_drain     (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .pmu_rst  (pmu_rst),
        .pmu_shdn (pmu_shdn),
        .core_rst (core_rst),
        .core_shdn(core_shdn),
        .rst_cause(rst_cause),
        .btn_db   (btn_db)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    int glen [4] = '{1, 3, 5, 2};

    initial begin
        rst_n    = 1'b0;
        btn_raw  = 1'b0;
        pmu_rst  = 1'b0;
        pmu_shdn = 1'b0;
        step(3);
        chk("por_rst",   {1'b0, core_rst},  2'd1);
        chk("por_shdn",  {1'b0, core_shdn}, 2'd0);
        chk("por_cause", rst_cause,         2'd0);
        chk("por_db",    {1'b0, btn_db},    2'd0);

        // Reset stretch after release: 4 cycles high in total.
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("por_hold_rst",  {1'b0, core_rst},  2'd1);
            chk("por_hold_shdn", {1'b0, core_shdn}, 2'd0);
        end
        step(1);
        chk("por_run_rst",   {1'b0, core_rst}, 2'd0);
        chk("por_run_cause", rst_cause,        2'd0);

        // Short glitches must be filtered out.
        for (int i = 0; i < 4; i++) begin
            btn_raw = 1'b1;
            step(glen[i]);
            btn_raw = 1'b0;
            step(6);
            chk("glitch_db",  {1'b0, btn_db},   2'd0);
            chk("glitch_rst", {1'b0, core_rst}, 2'd0);
        end

        // Real press: btn_db rises 10 edges after btn_raw, reset on the same edge.
        btn_raw = 1'b1;
        step(9);
        chk("press_early_db",  {1'b0, btn_db},   2'd0);
        chk("press_early_rst", {1'b0, core_rst}, 2'd0);
        step(1);
        chk("press_db",    {1'b0, btn_db},   2'd1);
        chk("press_rst",   {1'b0, core_rst}, 2'd1);
        chk("press_cause", rst_cause,        2'd1);
        step(3);
        chk("press_hold_rst", {1'b0, core_rst}, 2'd1);
        step(1);
        chk("press_run_rst", {1'b0, core_rst}, 2'd0);

        // Release has no effect beyond btn_db falling.
        btn_raw = 1'b0;
        step(12);
        chk("rel_db",  {1'b0, btn_db},   2'd0);
        chk("rel_rst", {1'b0, core_rst}, 2'd0);

        // Shutdown: one-cycle pmu_shdn, gate 3 edges after DRAIN entry.
        pmu_shdn = 1'b1;
        step(1);
        pmu_shdn = 1'b0;
        chk("drain_rst",  {1'b0, core_rst},  2'd0);
        chk("drain_shdn", {1'b0, core_shdn}, 2'd0);
        for (int i = 0; i < 2; i++) begin
            step(1);
            chk("drain_wait_shdn", {1'b0, core_shdn}, 2'd0);
        end
        step(1);
        chk("shdn_on", {1'b0, core_shdn}, 2'd1);
        // PMU requests are ignored while gated.
        pmu_rst  = 1'b1;
        pmu_shdn = 1'b1;
        step(5);
        chk("shdn_hold", {1'b0, core_shdn}, 2'd1);
        chk("shdn_norst", {1'b0, core_rst}, 2'd0);
        pmu_rst  = 1'b0;
        pmu_shdn = 1'b0;

        // Wake by press: gate drops and reset rises on the same edge.
        btn_raw = 1'b1;
        step(9);
        chk("wake_early_shdn", {1'b0, core_shdn}, 2'd1);
        step(1);
        chk("wake_shdn",  {1'b0, core_shdn}, 2'd0);
        chk("wake_rst",   {1'b0, core_rst},  2'd1);
        chk("wake_cause", rst_cause,         2'd3);
        step(3);
        chk("wake_hold_rst", {1'b0, core_rst}, 2'd1);
        step(1);
        chk("wake_run_rst", {1'b0, core_rst}, 2'd0);

        // Back into SHDN with the button still held (btn_db=1, cause=3).
        pmu_shdn = 1'b1;
        step(1);
        pmu_shdn = 1'b0;
        step(3);
        chk("shdn2_on",    {1'b0, core_shdn}, 2'd1);
        chk("shdn2_cause", rst_cause,         2'd3);
        chk("shdn2_db",    {1'b0, btn_db},    2'd1);

        // One-cycle rst_n while gated clears everything.
        rst_n   = 1'b0;
        btn_raw = 1'b0;
        step(1);
        chk("srst_shdn",  {1'b0, core_shdn}, 2'd0);
        chk("srst_rst",   {1'b0, core_rst},  2'd1);
        chk("srst_cause", rst_cause,         2'd0);
        chk("srst_db",    {1'b0, btn_db},    2'd0);
        rst_n = 1'b1;
        step(3);
        chk("srst_hold_rst", {1'b0, core_rst}, 2'd1);
        step(1);
        chk("srst_run_rst", {1'b0, core_rst}, 2'd0);

        // Press and pmu_rst on the same edge: button wins.
        btn_raw = 1'b1;
        step(9);
        pmu_rst = 1'b1;
        step(1);
        pmu_rst = 1'b0;
        chk("sim_rst",   {1'b0, core_rst}, 2'd1);
        chk("sim_cause", rst_cause,        2'd1);
        step(4);
        chk("sim_run_rst", {1'b0, core_rst}, 2'd0);
        btn_raw = 1'b0;
        step(12);
        chk("sim_rel_rst", {1'b0, core_rst}, 2'd0);

        // pmu_rst on the 2nd DRAIN cycle aborts the shutdown.
        pmu_shdn = 1'b1;
        step(1);
        pmu_shdn = 1'b0;
        step(1);
        chk("abort_pre_shdn", {1'b0, core_shdn}, 2'd0);
        pmu_rst = 1'b1;
        step(1);
        pmu_rst = 1'b0;
        chk("abort_rst",   {1'b0, core_rst},  2'd1);
        chk("abort_shdn",  {1'b0, core_shdn}, 2'd0);
        chk("abort_cause", rst_cause,         2'd2);
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("abort_never_shdn", {1'b0, core_shdn}, 2'd0);
        end
        chk("abort_run_rst", {1'b0, core_rst}, 2'd0);

        // Restart in RESET: press, then pmu_rst on the 3rd hold cycle -> 7 cycles.
        btn_raw = 1'b1;
        step(10);
        chk("rs_rst",   {1'b0, core_rst}, 2'd1);
        chk("rs_cause", rst_cause,        2'd1);
        step(2);
        pmu_rst = 1'b1;
        step(1);
        pmu_rst = 1'b0;
        chk("rs_restart_rst",   {1'b0, core_rst}, 2'd1);
        chk("rs_restart_cause", rst_cause,        2'd2);
        step(3);
        chk("rs_late_rst", {1'b0, core_rst}, 2'd1);
        step(1);
        chk("rs_run_rst",   {1'b0, core_rst}, 2'd0);
        chk("rs_run_cause", rst_cause,        2'd2);
        btn_raw = 1'b0;
        step(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
